// File: rtl/xor_stream_parity_pkg.sv
// Shared types and defaults for the xor_stream_parity block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding and default WIDTH / FRAME_LEN constants.
package xor_stream_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_FRAME_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // accumulator and counter are zero
    ACCUM = 2'd1,  // frame open, at least one word taken
    HOLD  = 2'd2   // result presented, waiting for sink
  } state_t;

endpackage

// File: rtl/xor_stream_parity_if.sv
// Handshake bundle between a word source/result sink and xor_stream_parity.
// Latency: n/a (wires only).
// Backpressure: in_ready/par_ready carry valid-ready flow control on each side.
// Ports: in_valid/in_ready/in_data/in_last (word stream), par_valid/par_ready/
//        par_data/par_bit/par_count (frame result), par_err only when
//        XOR_STREAM_PARITY_CHECK_EN is defined.
// Modports: master = source/sink side, slave = the parity block.
interface xor_stream_parity_if
  import xor_stream_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             par_valid;
  logic             par_ready;
  logic [WIDTH-1:0] par_data;
  logic             par_bit;
  logic [CNT_W-1:0] par_count;
`ifdef XOR_STREAM_PARITY_CHECK_EN
  logic             par_err;
`endif

  modport master (
    output in_valid, in_data, in_last, par_ready,
`ifdef XOR_STREAM_PARITY_CHECK_EN
    input  par_err,
`endif
    input  in_ready, par_valid, par_data, par_bit, par_count
  );

  modport slave (
    input  in_valid, in_data, in_last, par_ready,
`ifdef XOR_STREAM_PARITY_CHECK_EN
    output par_err,
`endif
    output in_ready, par_valid, par_data, par_bit, par_count
  );

endinterface

// File: rtl/xor_stream_parity_reduce.sv
// Combinational WIDTH-bit word reduction: XOR parity, or non-zero test.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: word (in), result (out). ZERO_TEST=1 turns the reduction into an OR,
//        so result=1 means "word is non-zero".
module xor_word_reduce #(
  parameter int WIDTH     = 8,
  parameter bit ZERO_TEST = 1'b0
) (
  input  logic [WIDTH-1:0] word,
  output logic             result
);

  generate
    if (ZERO_TEST) begin : g_nonzero
      assign result = |word;
    end else begin : g_parity
      assign result = ^word;
    end
  endgenerate

endmodule

// File: rtl/xor_stream_parity.sv
// Registered XOR accumulator: folds a word stream into one XOR word per frame.
// Latency: result valid one cycle after the closing word is accepted.
// Backpressure: in_ready drops while a result waits; par_ready stalls the result.
// Ports: clk, rst_n (async active-low), bus (xor_stream_parity_if.slave).
// Option: XOR_STREAM_PARITY_CHECK_EN adds par_err (frame XOR non-zero, i.e.
//         the trailing check word did not cancel the payload).
module xor_stream_parity
  import xor_stream_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_stream_parity_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             par_valid_q;
  logic [WIDTH-1:0] par_data_q;
  logic [CNT_W-1:0] par_count_q;

  logic             accept;
  logic             closing;
  logic [WIDTH-1:0] acc_next;

  // Ready depends only on state, never on par_ready.
  assign bus.in_ready = (state != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  // Word count limit: the FRAME_LEN-th word closes the frame even without
  // in_last, so cnt can never pass FRAME_LEN.
  assign closing      = bus.in_last || (cnt == CNT_W'(FRAME_LEN - 1));
  assign acc_next     = acc ^ bus.in_data;

  assign bus.par_valid = par_valid_q;
  assign bus.par_data  = par_data_q;
  assign bus.par_count = par_count_q;

  xor_word_reduce #(.WIDTH(WIDTH), .ZERO_TEST(1'b0)) u_par_bit (
    .word   (par_data_q),
    .result (bus.par_bit)
  );

`ifdef XOR_STREAM_PARITY_CHECK_EN
  logic par_err_q;
  logic frame_nonzero;

  // Tested on the next-frame value so the flag is registered with par_data.
  xor_word_reduce #(.WIDTH(WIDTH), .ZERO_TEST(1'b1)) u_zero_test (
    .word   (acc_next),
    .result (frame_nonzero)
  );

  assign bus.par_err = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (accept && closing) begin
      par_err_q <= frame_nonzero;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      par_valid_q <= 1'b0;
      par_data_q  <= '0;
      par_count_q <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (closing) begin
              state       <= HOLD;
              par_valid_q <= 1'b1;
              par_data_q  <= acc_next;
              par_count_q <= cnt + 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.par_ready) begin
            state       <= IDLE;
            par_valid_q <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_stream_parity.sv
// Bench for xor_stream_parity with WIDTH=8, FRAME_LEN=4: directed frames,
// backpressure, mid-frame reset, then random traffic against a frame-level model.
module tb_xor_stream_parity;
  import xor_stream_pkg::*;

  localparam int W  = 8;
  localparam int FL = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_stream_parity_if #(.WIDTH(W), .FRAME_LEN(FL)) bus ();

  xor_stream_parity #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: words of the open frame, plus the pending result.
  logic [W-1:0] frame_q[$];
  bit           res_vld = 1'b0;
  logic [W-1:0] res_data;
  int           res_cnt;

  function automatic void close_frame();
    res_data = '0;
    foreach (frame_q[i]) res_data = res_data ^ frame_q[i];
    res_cnt = frame_q.size();
    res_vld = 1'b1;
    frame_q.delete();
  endfunction

  task automatic compare(input string tag);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(!res_vld));
    check({tag, ".par_valid"}, 32'(bus.par_valid), 32'(res_vld));
    if (res_vld) begin
      check({tag, ".par_data"},  32'(bus.par_data),  32'(res_data));
      check({tag, ".par_count"}, 32'(bus.par_count), 32'(res_cnt));
      check({tag, ".par_bit"},   32'(bus.par_bit),   32'(^res_data));
`ifdef XOR_STREAM_PARITY_CHECK_EN
      check({tag, ".par_err"},   32'(bus.par_err),   32'(res_data != 0));
`endif
    end
  endtask

  // Drive one cycle of inputs at a negedge, predict, check at the next negedge.
  task automatic step(input string tag, input bit v, input logic [W-1:0] d,
                      input bit l, input bit pr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.par_ready = pr;
    if (res_vld) begin
      if (pr) res_vld = 1'b0;
    end else if (v) begin
      frame_q.push_back(d);
      if (l || frame_q.size() == FL) close_frame();
    end
    @(negedge clk);
    compare(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".par_valid"}, 32'(bus.par_valid), 32'd0);
    check({tag, ".par_data"},  32'(bus.par_data),  32'd0);
    check({tag, ".par_count"}, 32'(bus.par_count), 32'd0);
    check({tag, ".par_bit"},   32'(bus.par_bit),   32'd0);
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
`ifdef XOR_STREAM_PARITY_CHECK_EN
    check({tag, ".par_err"},   32'(bus.par_err),   32'd0);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.par_ready = 1'b0;

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame closed by the word count.
    step("full0", 1'b1, 8'h01, 1'b0, 1'b1);
    step("full1", 1'b1, 8'h02, 1'b0, 1'b1);
    step("full2", 1'b1, 8'h04, 1'b0, 1'b1);
    step("full3", 1'b1, 8'h08, 1'b0, 1'b0);
    check("full.data",  32'(bus.par_data),  32'h0F);
    check("full.count", 32'(bus.par_count), 32'd4);
    check("full.bit",   32'(bus.par_bit),   32'd0);

    // Backpressure, with the source still offering words.
    for (int i = 0; i < 5; i++)
      step("bp", 1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
    check("bp.data",  32'(bus.par_data),  32'h0F);
    check("bp.valid", 32'(bus.par_valid), 32'd1);
    step("bp.release", 1'b0, 8'h00, 1'b0, 1'b1);
    check("bp.in_ready", 32'(bus.in_ready), 32'd1);

    // Early close on in_last.
    step("early0", 1'b1, 8'hA5, 1'b0, 1'b1);
    step("early1", 1'b1, 8'h5A, 1'b1, 1'b0);
    check("early.data",  32'(bus.par_data),  32'hFF);
    check("early.count", 32'(bus.par_count), 32'd2);
    check("early.bit",   32'(bus.par_bit),   32'd0);
    step("early.drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Single-word frame.
    step("single", 1'b1, 8'h80, 1'b1, 1'b0);
    check("single.data",  32'(bus.par_data),  32'h80);
    check("single.count", 32'(bus.par_count), 32'd1);
    check("single.bit",   32'(bus.par_bit),   32'd1);
    step("single.drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    step("mid0", 1'b1, 8'h11, 1'b0, 1'b1);
    step("mid1", 1'b1, 8'h22, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    frame_q.delete();
    res_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    step("after_rst", 1'b1, 8'h03, 1'b1, 1'b0);
    check("after_rst.data",  32'(bus.par_data),  32'h03);
    check("after_rst.count", 32'(bus.par_count), 32'd1);
    step("after_rst.drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Check-word frames: good and corrupted.
    step("chk0", 1'b1, 8'h12, 1'b0, 1'b1);
    step("chk1", 1'b1, 8'h34, 1'b0, 1'b1);
    step("chk2", 1'b1, 8'h26, 1'b1, 1'b0);
    check("chk.good.data", 32'(bus.par_data), 32'h00);
`ifdef XOR_STREAM_PARITY_CHECK_EN
    check("chk.good.err",  32'(bus.par_err),  32'd0);
`endif
    step("chk.drain", 1'b0, 8'h00, 1'b0, 1'b1);
    step("bad0", 1'b1, 8'h12, 1'b0, 1'b1);
    step("bad1", 1'b1, 8'h34, 1'b0, 1'b1);
    step("bad2", 1'b1, 8'h27, 1'b1, 1'b0);
    check("chk.bad.data", 32'(bus.par_data), 32'h01);
`ifdef XOR_STREAM_PARITY_CHECK_EN
    check("chk.bad.err",  32'(bus.par_err),  32'd1);
`endif
    step("bad.drain", 1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic: idle gaps, stray in_last, random sink stalls.
    for (int i = 0; i < 600; i++) begin
      step("rand",
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_stream_parity.md
# xor_stream_parity

Parametrised, registered XOR accumulator for word streams. It accepts WIDTH-bit words over a valid/ready handshake and XORs them into a running accumulator. A frame closes on `in_last` or after FRAME_LEN words, and the block then presents the frame's XOR word, its parity bit and its word count on a second valid/ready interface. It sits between a data source and link-integrity logic, replacing per-bit gate-level XOR cells wherever a whole frame needs a parity word.

## Interface
- WIDTH, 8: data word width in bits; must be at least 1.
- FRAME_LEN, 16: maximum words per frame; must be at least 1.
- CNT_W, $clog2(FRAME_LEN+1): width of the word counter (derived; never overridden).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  source presents a word.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  input word.
- in_last  input  1  this word closes the frame.
- par_valid  output  1  frame result is available.
- par_ready  input  1  sink accepts the result.
- par_data  output  WIDTH  XOR of all words in the frame.
- par_bit  output  1  reduction XOR of `par_data`.
- par_count  output  CNT_W  number of words in the frame (1..FRAME_LEN).
- par_err  output  1  check-word mismatch; present only with the macro defined (see Configuration).

## Operation
- Three states:
  - IDLE: accumulator is 0 and count is 0.
  - ACCUM: at least one word accepted and the frame is still open.
  - HOLD: the result is being presented.
- An input word is accepted when `in_valid && in_ready`. On acceptance: `acc <= acc ^ in_data`, `cnt <= cnt + 1`.
- IDLE goes to ACCUM on an accepted word, or goes straight to HOLD if that word closes the frame.
- A word closes the frame when `in_last` is 1 or when it is the FRAME_LEN-th word. Either condition moves the block to HOLD. `in_last` on the FRAME_LEN-th word closes one frame, not two.
- `in_ready` is 1 in IDLE and ACCUM and 0 in HOLD. No word is accepted in HOLD.
- In HOLD, `par_valid` is 1 and `par_data`, `par_count` and `par_bit` are stable until `par_valid && par_ready`.
- On the output handshake: state goes to IDLE, and the accumulator and counter clear to 0.
- `in_data` is ignored when `in_valid` is 0.
- `in_last` without `in_valid` has no effect.
- `par_bit` is combinational from the registered `par_data`.
- The counter never exceeds FRAME_LEN. Any wrap is impossible because the frame closes at FRAME_LEN.
- Reset, asynchronous at any time including mid-frame or in HOLD:
  - state goes to IDLE;
  - `acc`, `cnt`, `par_valid`, `par_data`, `par_count`, `par_bit` and `par_err` go to 0;
  - `in_ready` goes to 1 once `rst_n` is high.
- No partial frame survives reset.

## Timing
- `par_valid` rises one cycle after the edge that accepts the closing word.
- `par_data` includes that closing word.
- `in_ready` returns to 1 in the cycle after the output handshake.
- Minimum frame period is (words + 1) cycles with `par_ready` held at 1.
- Output values are registered. Only `in_ready` and `par_bit` are combinational from state and registers.
- `in_ready` does not depend on `par_ready`, so there is no combinational in-to-out ready path.

## Configuration
- Macro: `XOR_STREAM_PARITY_CHECK_EN`.
- Defined:
  - the last word of every frame is a check word;
  - port `par_err` exists, registered alongside `par_data`;
  - `par_err` = 1 when the frame XOR is non-zero, and resets to 0.
- Undefined: `par_err` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `xor_stream_pkg` holds:
  - the state encoding typedef: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2;
  - the default WIDTH/FRAME_LEN constants.
- One sub-module, `xor_word_reduce`: a parametrised combinational WIDTH-bit reduction XOR. It drives `par_bit` and the check-mode zero test.
- The top level holds the FSM, accumulator, counter and output registers.

## Test plan
Benches use WIDTH=8, FRAME_LEN=4.
- Full frame, no `in_last`: words 0x01, 0x02, 0x04, 0x08 back-to-back -> `par_valid` one cycle after the 4th accept; `par_data`=0x0F, `par_bit`=0, `par_count`=4.
- Early close: 0xA5, then 0x5A with `in_last` -> `par_data`=0xFF, `par_count`=2, `par_bit`=0.
- Backpressure: `par_ready` low for 5 cycles in HOLD -> `par_valid` stays 1, outputs stable, `in_ready`=0. Raising `par_ready` -> handshake, then `in_ready`=1 next cycle.
- Single-word frame: 0x80 with `in_last` -> `par_data`=0x80, `par_count`=1, `par_bit`=1.
- Reset mid-frame: after 0x11 and 0x22 accepted, pulse `rst_n` low -> all outputs 0 and `in_ready`=1. Next frame 0x03 with `in_last` -> `par_data`=0x03, with no residue from the aborted frame.
- Check mode (macro defined):
  - 0x12, 0x34, then 0x26 with `in_last` -> `par_data`=0x00, `par_err`=0;
  - same frame with last word 0x27 -> `par_data`=0x01, `par_err`=1.
